// File: rtl/sram_like_slave_pkg.sv
// Shared definitions for the SRAM-like bus responder: size codes, response
// entry layout and timestamp arithmetic.
package sram_like_slave_pkg;

    localparam int TS_WD         = 5;
    localparam int DATA_WD       = 32;
    localparam int STRB_WD       = DATA_WD / 8;
    localparam int RESP_ENTRY_WD = 1 + DATA_WD + TS_WD;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic               wr;
        logic [DATA_WD-1:0] rdata;
        logic [TS_WD-1:0]   ts;
    } resp_entry_t;

    // Cycles elapsed since a timestamp, modulo the counter period.
    function automatic logic [TS_WD-1:0] ts_age(
        input logic [TS_WD-1:0] now,
        input logic [TS_WD-1:0] ts
    );
        return now - ts;
    endfunction

endpackage

// File: rtl/sram_like_slave_if.sv
// Request/response signals of one SRAM-like port (inst or data side).
interface sram_like_slave_if;
    import sram_like_slave_pkg::*;

    logic               req;
    logic               wr;
    logic [1:0]         size;
    logic [STRB_WD-1:0] wstrb;
    logic [31:0]        addr;
    logic [DATA_WD-1:0] wdata;
    logic               addr_ok;
    logic               data_ok;
    logic [DATA_WD-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_slave_resp_fifo.sv
// Generic synchronous FIFO holding accepted-but-unanswered responses.
module sram_like_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WD    = 38
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WD-1:0]            push_data,
    input  logic                     pop,
    output logic [WD-1:0]            head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WD-1:0] store_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    // Full is taken from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = store_reg[rd_ptr_reg];

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like bus responder: word memory, in-order response queue and a
// free-running timestamp that enforces the minimum response latency.
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_slave_if.slave     bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [TS_WD-1:0]         ts_reg;
    logic [AW-1:0]            word_idx;
    logic [7:0]               rd_byte [STRB_WD];
    logic [DATA_WD-1:0]       rd_word;
    logic                     accept;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic                     head_ready;
    logic                     resp_valid;
    resp_entry_t              push_entry;
    resp_entry_t              head_entry;
    logic [RESP_ENTRY_WD-1:0] head_bits;
    logic                     unused_bits;

    assign word_idx     = bus.addr[AW+1:2];
    assign bus.addr_ok  = !fifo_full && !reset;
    assign accept       = bus.req && bus.addr_ok;

    // One byte-wide array per lane so each write strobe maps onto its own RAM.
    for (genvar gi = 0; gi < STRB_WD; gi++) begin : g_lane
        logic [7:0] lane_mem [2**AW];

        always_ff @(posedge clk) begin
            if (accept && bus.wr && bus.wstrb[gi]) begin
                lane_mem[word_idx] <= bus.wdata[8*gi +: 8];
            end
        end

        assign rd_byte[gi] = lane_mem[word_idx];
    end

    assign rd_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
        end
    end

    // Read data is sampled into the queue at the accept edge.
    always_comb begin
        push_entry       = '0;
        push_entry.wr    = bus.wr;
        push_entry.rdata = bus.wr ? '0 : rd_word;
        push_entry.ts    = ts_reg;
    end

    sram_like_resp_fifo #(
        .DEPTH (DEPTH),
        .WD    (RESP_ENTRY_WD)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_entry),
        .pop       (resp_valid),
        .head_data (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_entry = resp_entry_t'(head_bits);
    assign head_ready = ts_age(ts_reg, head_entry.ts) >= TS_WD'(LATENCY);
    assign resp_valid = !reset && !fifo_empty && head_ready;

    assign bus.data_ok = resp_valid;
    assign bus.rdata   = (resp_valid && !head_entry.wr) ? head_entry.rdata : '0;

    // size is informational only; upper address bits alias by truncation.
    assign unused_bits = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0], fifo_count};

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three instances (LATENCY 2/4/1) share stimulus and
// are checked against a queue-based reference model plus directed sequences.
`timescale 1ns/1ps
module tb_sram_like_slave;
    import sram_like_slave_pkg::*;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic        aok [NI];
    logic        dok [NI];
    logic [31:0] rd  [NI];
    logic        s_aok [NI];
    logic        s_dok [NI];
    logic [31:0] s_rd  [NI];

    int total = 0;
    int bad = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;

    sram_like_slave_if bus_a ();
    sram_like_slave_if bus_b ();
    sram_like_slave_if bus_c ();

    assign bus_a.req = req;  assign bus_a.wr = wr;  assign bus_a.size = size;
    assign bus_a.wstrb = wstrb;  assign bus_a.addr = addr;  assign bus_a.wdata = wdata;
    assign bus_b.req = req;  assign bus_b.wr = wr;  assign bus_b.size = size;
    assign bus_b.wstrb = wstrb;  assign bus_b.addr = addr;  assign bus_b.wdata = wdata;
    assign bus_c.req = req;  assign bus_c.wr = wr;  assign bus_c.size = size;
    assign bus_c.wstrb = wstrb;  assign bus_c.addr = addr;  assign bus_c.wdata = wdata;

    assign aok[0] = bus_a.addr_ok;  assign dok[0] = bus_a.data_ok;  assign rd[0] = bus_a.rdata;
    assign aok[1] = bus_b.addr_ok;  assign dok[1] = bus_b.data_ok;  assign rd[1] = bus_b.rdata;
    assign aok[2] = bus_c.addr_ok;  assign dok[2] = bus_c.data_ok;  assign rd[2] = bus_c.rdata;

    sram_like_slave #(.AW(10), .DEPTH(4), .LATENCY(2)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
    sram_like_slave #(.AW(10), .DEPTH(4), .LATENCY(4)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));
    sram_like_slave #(.AW(10), .DEPTH(2), .LATENCY(1)) dut_c (.clk(clk), .reset(rst), .bus(bus_c));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int dep_of(input int k);
        return (k == 2) ? 2 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc_n);
        end
    endtask

    // ---------------- reference model: outstanding list with accept times ----
    typedef struct {
        int          inst;
        logic        wr;
        logic [31:0] data;
        logic [31:0] mask;
        int          acc;
    } ment_t;

    ment_t       mq [$];
    logic [31:0] mmem [NI][1024];
    bit   [3:0]  mval [NI][1024];

    always @(negedge clk) begin : model
        int          cnt;
        int          hi;
        int          idx;
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_rd;
        logic [31:0] e_mask;
        ment_t       ne;
        for (int k = 0; k < NI; k++) begin
            cnt = 0;
            hi = -1;
            for (int j = 0; j < mq.size(); j++) begin
                if (mq[j].inst == k) begin
                    if (hi < 0) hi = j;
                    cnt++;
                end
            end
            e_aok = !rst && (cnt < dep_of(k));
            e_dok = 1'b0;
            if (!rst && hi >= 0) e_dok = (cyc_n - mq[hi].acc) >= lat_of(k);
            e_rd = 32'h0;
            e_mask = 32'hFFFF_FFFF;
            if (e_dok && !mq[hi].wr) begin
                e_rd = mq[hi].data;
                e_mask = mq[hi].mask;
            end
            check($sformatf("model_addr_ok[%0d]", k), {31'b0, aok[k]}, {31'b0, e_aok});
            check($sformatf("model_data_ok[%0d]", k), {31'b0, dok[k]}, {31'b0, e_dok});
            check($sformatf("model_rdata[%0d]", k), rd[k] & e_mask, e_rd & e_mask);
            if (!rst) begin
                if (e_dok) mq.delete(hi);
                if (req && e_aok) begin
                    idx = int'(addr[11:2]);
                    ne.inst = k;
                    ne.wr = wr;
                    ne.acc = cyc_n;
                    ne.data = 32'h0;
                    ne.mask = 32'h0;
                    if (wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[b]) begin
                                mmem[k][idx][8*b +: 8] = wdata[8*b +: 8];
                                mval[k][idx][b] = 1'b1;
                            end
                        end
                    end else begin
                        ne.data = mmem[k][idx];
                        for (int b = 0; b < 4; b++) ne.mask[8*b +: 8] = {8{mval[k][idx][b]}};
                    end
                    mq.push_back(ne);
                end
            end
        end
        if (rst) mq.delete();
        cyc_n++;
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic apply(input logic r, input logic q, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        rst = r;  req = q;  wr = w;  wstrb = s;  addr = a;  wdata = d;
        size = 2'd2;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            s_aok[k] = aok[k];
            s_dok[k] = dok[k];
            s_rd[k]  = rd[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        r, q, w;
        logic [3:0]  s;
        logic [31:0] a, d;
        logic        e_aok, e_dok;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [10];

    initial begin : stim
        logic [6:0]  exp_aok_b;
        logic [11:0] exp_dok_b;

        // Directed vectors for the LATENCY=2 instance.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF,  1'b1, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 1'b1, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 4'h2, 32'h41, 32'h0000AA00,  1'b1, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h41, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 1'b1, 32'hDEADAAEF};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0,         1'b1, 1'b0, 32'h0};

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].r, tbl[i].q, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d_addr_ok", i), {31'b0, s_aok[0]}, {31'b0, tbl[i].e_aok});
            check($sformatf("tbl%0d_data_ok", i), {31'b0, s_dok[0]}, {31'b0, tbl[i].e_dok});
            check($sformatf("tbl%0d_rdata", i), s_rd[0], tbl[i].e_rd);
        end

        // Back-pressure: DEPTH=4, LATENCY=4 with req held for 7 cycles.
        idle(8);
        exp_aok_b = 7'b1101111;
        exp_dok_b = 12'b011011110000;
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, i < 7, 1'b0, 4'h0, 32'h40, 32'h0);
            if (i < 7) check($sformatf("full_addr_ok_c%0d", i), {31'b0, s_aok[1]}, {31'b0, exp_aok_b[i]});
            check($sformatf("full_data_ok_c%0d", i), {31'b0, s_dok[1]}, {31'b0, exp_dok_b[i]});
            if (exp_dok_b[i]) check($sformatf("full_rdata_c%0d", i), s_rd[1], 32'hDEADAAEF);
        end

        // LATENCY=1 streaming reads of preloaded words.
        idle(8);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b1, 4'hF, 32'(i * 4), 32'(i + 1));
        idle(4);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, i < 3, 1'b0, 4'h0, 32'(i * 4), 32'h0);
            if (i < 3) check($sformatf("lat1_addr_ok_%0d", i), {31'b0, s_aok[2]}, 32'h1);
            check($sformatf("lat1_data_ok_%0d", i), {31'b0, s_dok[2]}, {31'b0, (i >= 1 && i <= 3)});
            check($sformatf("lat1_rdata_%0d", i), s_rd[2], (i >= 1 && i <= 3) ? 32'(i) : 32'h0);
        end

        // Reset with outstanding reads: responses dropped, memory retained.
        idle(8);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            for (int k = 0; k < NI; k++) begin
                check($sformatf("rst_addr_ok[%0d]", k), {31'b0, s_aok[k]}, 32'h0);
                check($sformatf("rst_data_ok[%0d]", k), {31'b0, s_dok[k]}, 32'h0);
            end
        end
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            for (int k = 0; k < NI; k++) begin
                if (i == 0) check($sformatf("post_rst_addr_ok[%0d]", k), {31'b0, s_aok[k]}, 32'h1);
                check($sformatf("post_rst_data_ok[%0d]", k), {31'b0, s_dok[k]}, 32'h0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, i == 0, 1'b0, 4'h0, 32'h40, 32'h0);
            check($sformatf("retain_data_ok_%0d", i), {31'b0, s_dok[0]}, {31'b0, i == 2});
            check($sformatf("retain_rdata_%0d", i), s_rd[0], (i == 2) ? 32'hDEADAAEF : 32'h0);
        end

        // Long idle so the timestamp counter wraps, then one read.
        idle(40);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, i == 0, 1'b0, 4'h0, 32'h8, 32'h0);
            check($sformatf("wrap_data_ok_a_%0d", i), {31'b0, s_dok[0]}, {31'b0, i == 2});
            check($sformatf("wrap_rdata_a_%0d", i), s_rd[0], (i == 2) ? 32'h3 : 32'h0);
            check($sformatf("wrap_data_ok_c_%0d", i), {31'b0, s_dok[2]}, {31'b0, i == 1});
        end

        // Random traffic with aliased addresses and occasional reset.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom & 32'hFFFF_F03F, $urandom);
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
